// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch stage: word size, bubble encoding,
// default reset PC, the {pc, inst} fetch entry and the sequential-PC helper.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_BUBBLE      = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Next sequential fetch address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries with a flush input and an occupancy
// count. Used both as the prefetch buffer and as the PC shadow queue.
// Callers never push when full or pop when empty.
module ifetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointer and occupancy update; a flush empties the queue and overrides push/pop.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch stage. Issues in-order word fetches under a credit
// limit so the prefetch FIFO can never overflow, tags returning words with
// their PCs from a shadow queue, and presents one {pc, inst} per cycle to IF/ID.
// A redirect (PCsrc) flushes buffered words and discards in-flight responses.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN -- a misaligned redirect
// target pulses misalign_o and halts fetching until the next redirect.
// Without it, the target's low two bits are forced to zero.
module ifetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            clrn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            ifid_write,
  input  logic            PCsrc,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            inst_valid,
  output logic            misalign_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   shadow_count;
  logic            halted;
  logic            handshake;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            push;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    shadow_head;
  fetch_entry_t    push_entry;
  fetch_entry_t    shadow_entry;
  logic            shadow_unused;

  assign handshake = imem_req_valid && imem_req_ready;
  assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0);
  assign push      = rsp_keep && !PCsrc;
  assign pop       = inst_valid && ifid_write && !PCsrc;

  // Only request when a buffer slot is guaranteed for every word already in flight.
  assign imem_req_valid = clrn && !PCsrc && !halted &&
                          (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;

  assign shadow_entry = '{pc: fetch_pc, inst: INST_BUBBLE};
  assign push_entry   = '{pc: shadow_head.pc, inst: imem_rdata};

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic target_misaligned;
  logic misalign_q;
  logic halted_q;

  assign target_misaligned = (pc_target[1:0] != 2'b00);
  assign redirect_pc       = target_misaligned ? fetch_pc : pc_target;
  assign halted            = halted_q;
  assign misalign_o        = misalign_q;

  // Misaligned redirect: one-cycle flag, and fetching stays halted until the next redirect.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      misalign_q <= PCsrc && target_misaligned;
      if (PCsrc) halted_q <= target_misaligned;
    end
  end

  assign shadow_unused = ^{shadow_count, shadow_head.inst};
`else
  assign redirect_pc   = {pc_target[XLEN-1:2], 2'b00};
  assign halted        = 1'b0;
  assign misalign_o    = 1'b0;
  assign shadow_unused = ^{shadow_count, shadow_head.inst, pc_target[1:0]};
`endif

  // Fetch PC and counters; on redirect every word still in flight after this edge is marked for discard.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(handshake) - CW'(imem_rsp_valid);
      if (PCsrc) begin
        fetch_pc <= redirect_pc;
        drop_cnt <= outstanding + CW'(handshake) - CW'(imem_rsp_valid);
      end else begin
        if (handshake) fetch_pc <= pc_next(fetch_pc);
        if (rsp_drop)  drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_prefetch (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (PCsrc),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_pc_shadow (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (PCsrc),
    .push      (handshake),
    .push_data (shadow_entry),
    .pop       (push),
    .head      (shadow_head),
    .count     (shadow_count)
  );

  assign inst_valid = (fifo_count != '0);
  assign pc_o       = inst_valid ? head.pc   : '0;
  assign inst_o     = inst_valid ? head.inst : INST_BUBBLE;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. A behavioural memory answers requests in
// order after a random latency; a stream model predicts the next request
// address and the next presented PC from the redirect/handshake/pop history.
`timescale 1ns/1ps
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ifid_write = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] pc_target = '0;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        misalign_o;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .ifid_write(ifid_write), .PCsrc(PCsrc), .pc_target(pc_target),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid(inst_valid), .misalign_o(misalign_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int lat_extra = 0;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  logic [31:0] exp_pc;
  logic [31:0] exp_addr;
  bit          halted_m;
  bit          exp_mis;

  logic        s_req_valid, s_inst_valid, s_misalign;
  logic [31:0] s_addr, s_pc, s_inst;
  bit          s_hs, s_pop;

  // Memory contents: a PC-dependent word, nonzero at address 0 so bubbles stand out.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic reset_model();
    exp_pc   = RESET_PC;
    exp_addr = RESET_PC;
    halted_m = 1'b0;
    exp_mis  = 1'b0;
    mem_addr_q.delete();
    mem_due_q.delete();
  endtask

  // One clock: drive the memory response, sample DUT outputs at the falling edge, then update memory.
  task automatic tick();
    int due;
    imem_rsp_valid = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
    imem_rdata     = imem_rsp_valid ? mem_word(mem_addr_q[0]) : $urandom;
    @(negedge clk);
    s_req_valid  = imem_req_valid;
    s_addr       = imem_addr;
    s_inst_valid = inst_valid;
    s_pc         = pc_o;
    s_inst       = inst_o;
    s_misalign   = misalign_o;
    s_hs         = imem_req_valid && imem_req_ready;
    s_pop        = inst_valid && ifid_write && !PCsrc;
    @(posedge clk);
    if (imem_rsp_valid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (s_hs) begin
      due = cyc + 1 + lat_extra;
      if (mem_due_q.size() > 0 && mem_due_q[$] > due) due = mem_due_q[$];
      mem_addr_q.push_back(s_addr);
      mem_due_q.push_back(due);
    end
    if (s_pop) pops++;
    cyc++;
    #1;
  endtask

  // Advance the stream model using this cycle's inputs and sampled events.
  task automatic model_step();
    exp_mis = 1'b0;
    if (PCsrc) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (pc_target[1:0] != 2'b00) begin
        halted_m = 1'b1;
        exp_mis  = 1'b1;
      end else begin
        halted_m = 1'b0;
        exp_addr = pc_target;
        exp_pc   = pc_target;
      end
`else
      exp_addr = {pc_target[31:2], 2'b00};
      exp_pc   = exp_addr;
`endif
    end else begin
      if (s_hs)  exp_addr = exp_addr + 32'd4;
      if (s_pop) exp_pc   = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    int first_valid = -1;
    logic [31:0] first_pc = '1;
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_o: got %h expected 0", pc_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_o: got %h expected 0", inst_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign_o); end
    @(posedge clk);
    #1;
    clrn = 1'b1;
    reset_model();
    imem_req_ready = 1'b1; ifid_write = 1'b1; PCsrc = 1'b0; lat_extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("[TB] FAIL first_request: got valid=%b addr=%h expected valid=1 addr=%h", s_req_valid, s_addr, RESET_PC); end
      end
      if (s_inst_valid && first_valid < 0) begin first_valid = i; first_pc = s_pc; end
      model_step();
    end
    checks++; if (first_valid != 2) begin errors++; $display("[TB] FAIL first_valid_cycle: got %0d expected 2", first_valid); end
    checks++; if (first_pc !== RESET_PC) begin errors++; $display("[TB] FAIL first_pc: got %h expected %h", first_pc, RESET_PC); end
  endtask

  task automatic test_traffic(input string tag, input int n, input int ready_pct, input int write_pct,
                              input int redir_pct, input int max_lat, input int min_pops);
    int pops0 = pops;
    for (int i = 0; i < n; i++) begin
      imem_req_ready = ($urandom_range(99) < ready_pct);
      ifid_write     = ($urandom_range(99) < write_pct);
      PCsrc          = ($urandom_range(99) < redir_pct);
      pc_target      = $urandom;
      if ($urandom_range(1) == 1) pc_target[1:0] = 2'b00;
      lat_extra      = $urandom_range(max_lat);
      tick();
      checks++; if (s_req_valid && (PCsrc || halted_m)) begin errors++; $display("[TB] FAIL %s req_gate: got valid=1 expected 0 (PCsrc=%b halted=%b)", tag, PCsrc, halted_m); end
      if (s_req_valid) begin
        checks++; if (s_addr !== exp_addr) begin errors++; $display("[TB] FAIL %s req_addr: got %h expected %h", tag, s_addr, exp_addr); end
      end
      if (s_inst_valid) begin
        checks++; if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin errors++; $display("[TB] FAIL %s head: got pc=%h inst=%h expected pc=%h inst=%h", tag, s_pc, s_inst, exp_pc, mem_word(exp_pc)); end
      end else begin
        checks++; if (s_pc !== 32'h0 || s_inst !== 32'h0) begin errors++; $display("[TB] FAIL %s bubble: got pc=%h inst=%h expected 0", tag, s_pc, s_inst); end
      end
      checks++; if (s_misalign !== exp_mis) begin errors++; $display("[TB] FAIL %s misalign: got %b expected %b", tag, s_misalign, exp_mis); end
      checks++; if (mem_addr_q.size() > DEPTH) begin errors++; $display("[TB] FAIL %s credit: got %0d in flight expected <= %0d", tag, mem_addr_q.size(), DEPTH); end
      model_step();
    end
    PCsrc = 1'b0;
    checks++; if (pops - pops0 < min_pops) begin errors++; $display("[TB] FAIL %s progress: got %0d pops expected >= %0d", tag, pops - pops0, min_pops); end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc = '0;
    int pops0;
    imem_req_ready = 1'b1; ifid_write = 1'b0; PCsrc = 1'b0; lat_extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) held_pc = s_pc;
      if (i >= 2) begin
        checks++; if (s_inst_valid !== 1'b1 || s_pc !== held_pc) begin errors++; $display("[TB] FAIL stall_hold: got valid=%b pc=%h expected valid=1 pc=%h", s_inst_valid, s_pc, held_pc); end
      end
      if (i == 4) begin
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_credit: got req_valid=%b expected 0", s_req_valid); end
      end
      model_step();
    end
    ifid_write = 1'b1;
    pops0 = pops;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_inst_valid) begin
        checks++; if (s_pc !== exp_pc) begin errors++; $display("[TB] FAIL stall_release: got pc=%h expected %h", s_pc, exp_pc); end
      end
      model_step();
    end
    checks++; if (pops - pops0 < 4) begin errors++; $display("[TB] FAIL stall_progress: got %0d pops expected >= 4", pops - pops0); end
  endtask

  // Empty the pipeline: stop requesting and let IF/ID consume everything.
  task automatic drain();
    imem_req_ready = 1'b0; ifid_write = 1'b1; PCsrc = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); model_step(); end
  endtask

  // Run after a redirect and require that the first request and first presented PC are the target.
  task automatic expect_restart(input string tag, input logic [31:0] target);
    bit seen_req = 0;
    bit seen_inst = 0;
    imem_req_ready = 1'b1; ifid_write = 1'b1; PCsrc = 1'b0; lat_extra = 0;
    for (int i = 0; i < 20 && !seen_inst; i++) begin
      tick();
      if (s_req_valid && !seen_req) begin
        seen_req = 1;
        checks++; if (s_addr !== target) begin errors++; $display("[TB] FAIL %s first_req: got %h expected %h", tag, s_addr, target); end
      end
      if (s_inst_valid) begin
        seen_inst = 1;
        checks++; if (s_pc !== target || s_inst !== mem_word(target)) begin errors++; $display("[TB] FAIL %s first_inst: got pc=%h inst=%h expected pc=%h inst=%h", tag, s_pc, s_inst, target, mem_word(target)); end
      end
      model_step();
    end
    checks++; if (!seen_inst) begin errors++; $display("[TB] FAIL %s timeout: got no valid instruction expected pc=%h", tag, target); end
  endtask

  task automatic test_redirect_inflight();
    drain();
    imem_req_ready = 1'b1; ifid_write = 1'b0; lat_extra = 4;
    for (int i = 0; i < 10 && mem_addr_q.size() < 2; i++) begin tick(); model_step(); end
    checks++; if (mem_addr_q.size() != 2) begin errors++; $display("[TB] FAIL redir_setup: got %0d in flight expected 2", mem_addr_q.size()); end
    PCsrc = 1'b1; pc_target = 32'h0000_0100;
    tick();
    checks++; if (s_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_req_gate: got %b expected 0", s_req_valid); end
    model_step();
    expect_restart("redir_inflight", 32'h0000_0100);
  endtask

  task automatic test_redirect_with_rsp();
    drain();
    imem_req_ready = 1'b1; ifid_write = 1'b0; lat_extra = 0;
    repeat (2) begin tick(); model_step(); end
    PCsrc = 1'b1; pc_target = 32'h0000_0300;
    tick();
    checks++; if (imem_rsp_valid !== 1'b1 || s_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_rsp_cycle: got rsp=%b req=%b expected rsp=1 req=0", imem_rsp_valid, s_req_valid); end
    model_step();
    expect_restart("redir_rsp", 32'h0000_0300);
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    PCsrc = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick(); model_step();
    PCsrc = 1'b0; imem_req_ready = 1'b1; ifid_write = 1'b1; lat_extra = 0;
    for (int i = 0; i < 20 && pcs.size() < 2; i++) begin
      tick();
      if (s_hs) addrs.push_back(s_addr);
      if (s_pop) pcs.push_back(s_pc);
      model_step();
    end
    checks++; if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr: got %0d addrs first=%h expected FFFFFFFC then 00000000", addrs.size(), addrs.size() > 0 ? addrs[0] : 32'hx); end
    checks++; if (pcs.size() < 2 || pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc: got %0d pcs first=%h expected FFFFFFFC then 00000000", pcs.size(), pcs.size() > 0 ? pcs[0] : 32'hx); end
  endtask

  task automatic test_misalign();
    imem_req_ready = 1'b1; ifid_write = 1'b1;
    PCsrc = 1'b1; pc_target = 32'h0000_0102;
    tick(); model_step();
    PCsrc = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (s_misalign !== (i == 0)) begin errors++; $display("[TB] FAIL misalign_pulse: cycle %0d got %b expected %b", i, s_misalign, i == 0); end
      checks++; if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL misalign_halt: cycle %0d got req=%b inst=%b expected 0", i, s_req_valid, s_inst_valid); end
      model_step();
    end
    PCsrc = 1'b1; pc_target = 32'h0000_0200;
    tick(); model_step();
    expect_restart("misalign_resume", 32'h0000_0200);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_misalign !== 1'b0) begin errors++; $display("[TB] FAIL misalign_tied: got %b expected 0", s_misalign); end
      model_step();
    end
    drain();
    PCsrc = 1'b1; pc_target = 32'h0000_0102;
    tick(); model_step();
    expect_restart("misalign_forced", 32'h0000_0100);
`endif
  endtask

  task automatic test_mid_reset();
    imem_req_ready = 1'b1; ifid_write = 1'b1; PCsrc = 1'b0; lat_extra = 2;
    repeat (4) begin tick(); model_step(); end
    #2;
    clrn = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset: got req=%b valid=%b pc=%h inst=%h expected all 0", imem_req_valid, inst_valid, pc_o, inst_o); end
    imem_rsp_valid = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
    clrn = 1'b1;
    lat_extra = 0;
    tick();
    checks++; if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("[TB] FAIL mid_reset_restart: got valid=%b addr=%h expected valid=1 addr=%h", s_req_valid, s_addr, RESET_PC); end
    model_step();
  endtask

  initial begin
    test_reset();
    test_traffic("basic", 40, 100, 100, 0, 0, 10);
    test_stall();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_wrap();
    test_misalign();
    test_mid_reset();
    test_traffic("random", 400, 70, 70, 5, 3, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
